axis_14_to_sc28: RTL and testbench

AXIS_14_TO_SC28 -- requirements
Module: axis_14_to_sc28

---
 rtl/axis_14_to_sc28.sv | 156 +++++++++++++++
 tb/tb_axis_14_to_sc28.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_14_to_sc28.sv
// rtl/axis_14_to_sc28.sv - ADC lanes to sign-extended channels through a 2-entry skid buffer
// Optional saturation counter: define AXIS_14_TO_SC28_SATCNT_EN
module axis_14_to_sc28 #(
  parameter int ADC_WIDTH        = 14,
  parameter int SRC_BITS         = 26,
  parameter int SAXIS_DATA_WIDTH = 16,
  parameter int MAXIS_DATA_WIDTH = 32
) (
  input  logic                          a_clk,
  input  logic                          a_rst,
  input  logic [2*SAXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  output logic [2*MAXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [SAXIS_DATA_WIDTH-1:0]   M_AXIS_aux_tdata,
  output logic                          M_AXIS_aux_tvalid,
  input  logic                          sat_clr,
  output logic [31:0]                   sat_count
);

  localparam int SW = SAXIS_DATA_WIDTH;
  localparam int MW = MAXIS_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // A lane is well-formed when every bit from the top down to the ADC sign bit agrees.
  function automatic logic f_malformed(input logic [SW-1:0] lane);
    logic [SW-ADC_WIDTH:0] top;
    top = lane[SW-1:ADC_WIDTH-1];
    return !((&top) || (~|top));
  endfunction

  // Malformed lanes clip toward the side indicated by the lane's top bit.
  function automatic logic [ADC_WIDTH-1:0] f_value(input logic [SW-1:0] lane);
    if (!f_malformed(lane)) begin
      return lane[ADC_WIDTH-1:0];
    end else if (lane[SW-1]) begin
      return {1'b1, {(ADC_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(ADC_WIDTH-1){1'b1}}};
    end
  endfunction

  // Value sits at the top of the SRC_BITS field, zero-filled below, sign-extended above.
  function automatic logic [MW-1:0] f_chan(input logic [ADC_WIDTH-1:0] v);
    return {{(MW-SRC_BITS){v[ADC_WIDTH-1]}}, v, {(SRC_BITS-ADC_WIDTH){1'b0}}};
  endfunction

  state_t            r_state;
  logic [2*MW-1:0]   r_main;
  logic [2*MW-1:0]   r_skid;
  logic              r_m_tvalid;
  logic              r_s_tready;

  logic [SW-1:0]     w_lane0;
  logic [SW-1:0]     w_lane1;
  logic              w_clip0;
  logic              w_clip1;
  logic [2*MW-1:0]   w_beat;
  logic              w_accept;
  logic              w_consume;

  assign w_lane0   = S_AXIS_tdata[SW-1:0];
  assign w_lane1   = S_AXIS_tdata[2*SW-1:SW];
  assign w_clip0   = f_malformed(w_lane0);
  assign w_clip1   = f_malformed(w_lane1);
  assign w_beat    = {f_chan(f_value(w_lane1)), f_chan(f_value(w_lane0))};
  assign w_accept  = S_AXIS_tvalid && r_s_tready;
  assign w_consume = r_m_tvalid && M_AXIS_tready;

  // Skid-buffer control: main register feeds the outputs, skid catches one beat
  // while the consumer stalls; tready is registered and drops only in FULL.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_m_tvalid <= 1'b0;
      r_s_tready <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_s_tready <= 1'b1;
          if (w_accept) begin
            r_main     <= w_beat;
            r_m_tvalid <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_consume) begin
            r_skid     <= w_beat;
            r_s_tready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (!w_accept && w_consume) begin
            r_m_tvalid <= 1'b0;
            r_state    <= ST_EMPTY;
          end else if (w_accept && w_consume) begin
            r_main     <= w_beat;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            r_main     <= r_skid;
            r_s_tready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_m_tvalid <= 1'b0;
          r_s_tready <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXIS_tready     = r_s_tready;
  assign M_AXIS_tvalid     = r_m_tvalid;
  assign M_AXIS_aux_tvalid = r_m_tvalid;
  assign M_AXIS_tdata      = r_main;
  assign M_AXIS_aux_tdata  = {r_main[MW+SRC_BITS-1 -: ADC_WIDTH], {(SW-ADC_WIDTH){1'b0}}};

`ifdef AXIS_14_TO_SC28_SATCNT_EN
  logic [31:0] r_sat_count;
  logic [1:0]  w_clip_n;
  logic [32:0] w_sat_sum;

  assign w_clip_n  = {1'b0, w_clip0} + {1'b0, w_clip1};
  assign w_sat_sum = {1'b0, r_sat_count} + {31'b0, w_clip_n};

  // Clip-event counter; clear wins over a same-cycle increment, and the count sticks at all-ones.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_accept) begin
      r_sat_count <= w_sat_sum[32] ? '1 : w_sat_sum[31:0];
    end
  end

  assign sat_count = r_sat_count;
`else
  logic w_unused_satcnt;
  assign w_unused_satcnt = &{1'b0, sat_clr, w_clip0, w_clip1};
  assign sat_count       = '0;
`endif

endmodule

// File: tb/tb_axis_14_to_sc28.sv
// tb/tb_axis_14_to_sc28.sv - directed vector and sequence bench for axis_14_to_sc28
module tb_axis_14_to_sc28;

`ifdef AXIS_14_TO_SC28_SATCNT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        a_clk = 1'b0;
  logic        a_rst;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [63:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [15:0] M_AXIS_aux_tdata;
  logic        M_AXIS_aux_tvalid;
  logic        sat_clr;
  logic [31:0] sat_count;

  int errors = 0;
  int checks = 0;
  int exp_sat = 0;

  axis_14_to_sc28 dut (
    .a_clk             (a_clk),
    .a_rst             (a_rst),
    .S_AXIS_tdata      (S_AXIS_tdata),
    .S_AXIS_tvalid     (S_AXIS_tvalid),
    .S_AXIS_tready     (S_AXIS_tready),
    .M_AXIS_tdata      (M_AXIS_tdata),
    .M_AXIS_tvalid     (M_AXIS_tvalid),
    .M_AXIS_tready     (M_AXIS_tready),
    .M_AXIS_aux_tdata  (M_AXIS_aux_tdata),
    .M_AXIS_aux_tvalid (M_AXIS_aux_tvalid),
    .sat_clr           (sat_clr),
    .sat_count         (sat_count)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    logic [31:0] din;
    logic [63:0] dout;
    logic [15:0] aux;
    int          clips;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge a_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int clamp(input logic [15:0] lane, inout int clips);
    int s;
    s = int'($signed(lane));
    if (s > 8191) begin
      s = 8191;
      clips++;
    end else if (s < -8192) begin
      s = -8192;
      clips++;
    end
    return s;
  endfunction

  function automatic logic [79:0] model(input logic [31:0] din, inout int clips);
    int          v0;
    int          v1;
    int          a;
    logic [31:0] c0;
    logic [31:0] c1;
    v0 = clamp(din[15:0], clips);
    v1 = clamp(din[31:16], clips);
    c0 = v0 * 4096;
    c1 = v1 * 4096;
    a  = (v1 & 32'h3FFF) << 2;
    return {a[15:0], c1, c0};
  endfunction

  function automatic logic [15:0] rnd_lane();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return r[15:0];
    return {{2{r[13]}}, r[13:0]};
  endfunction

  logic [79:0] q[$];

  initial begin
    int sent;
    int got;
    int cyc;
    int cl;
    bit acc;
    bit cons;
    logic [79:0] e;

    vecs[0] = '{32'hFFFF0001, 64'hFFFFF000_00001000, 16'hFFFC, 0};
    vecs[1] = '{32'h80004000, 64'hFE000000_01FFF000, 16'h8000, 2};
    vecs[2] = '{32'h00000000, 64'h00000000_00000000, 16'h0000, 0};
    vecs[3] = '{32'h1FFFE000, 64'h01FFF000_FE000000, 16'h7FFC, 0};
    vecs[4] = '{32'h2000DFFF, 64'h01FFF000_FE000000, 16'h7FFC, 2};
    vecs[5] = '{32'hE0011234, 64'hFE001000_01234000, 16'h8004, 0};
    vecs[6] = '{32'h7FFF0FFF, 64'h01FFF000_00FFF000, 16'h7FFC, 1};

    a_rst = 1'b1;
    S_AXIS_tdata = '0;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b0;
    sat_clr = 1'b0;
    step();
    step();
    chk("rst_tvalid", M_AXIS_tvalid, 0);
    chk("rst_aux_tvalid", M_AXIS_aux_tvalid, 0);
    chk("rst_tready", S_AXIS_tready, 0);
    chk("rst_tdata", M_AXIS_tdata, 0);
    chk("rst_aux", M_AXIS_aux_tdata, 0);
    chk("rst_sat", sat_count, 0);
    a_rst = 1'b0;
    step();
    chk("post_rst_tready", S_AXIS_tready, 1);
    chk("post_rst_tvalid", M_AXIS_tvalid, 0);

    // conversion vectors, one isolated beat each
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      S_AXIS_tdata  = vecs[i].din;
      S_AXIS_tvalid = 1'b1;
      step();
      S_AXIS_tvalid = 1'b0;
      if (SAT_ON) exp_sat += vecs[i].clips;
      chk($sformatf("vec%0d_tvalid", i), M_AXIS_tvalid, 1);
      chk($sformatf("vec%0d_aux_tvalid", i), M_AXIS_aux_tvalid, 1);
      chk($sformatf("vec%0d_tdata", i), M_AXIS_tdata, vecs[i].dout);
      chk($sformatf("vec%0d_aux", i), M_AXIS_aux_tdata, vecs[i].aux);
      chk($sformatf("vec%0d_sat", i), sat_count, exp_sat);
      step();
      chk($sformatf("vec%0d_drain", i), M_AXIS_tvalid, 0);
    end

    // clear collides with a clipped beat: clear wins
    chk("sat_before_clr", sat_count, SAT_ON ? 5 : 0);
    S_AXIS_tdata  = 32'h80004000;
    S_AXIS_tvalid = 1'b1;
    sat_clr       = 1'b1;
    step();
    S_AXIS_tvalid = 1'b0;
    sat_clr       = 1'b0;
    chk("sat_clr_priority", sat_count, 0);
    chk("sat_clr_tdata", M_AXIS_tdata, 64'hFE000000_01FFF000);
    exp_sat = 0;
    step();

    // A,B,C back-to-back against a stalled consumer
    M_AXIS_tready = 1'b0;
    S_AXIS_tdata  = vecs[0].din;
    S_AXIS_tvalid = 1'b1;
    step();
    chk("bp_a_tvalid", M_AXIS_tvalid, 1);
    chk("bp_a_tready", S_AXIS_tready, 1);
    S_AXIS_tdata = vecs[3].din;
    step();
    chk("bp_full_tready", S_AXIS_tready, 0);
    chk("bp_full_data", M_AXIS_tdata, vecs[0].dout);
    S_AXIS_tdata = vecs[5].din;
    step();
    step();
    chk("bp_hold_tready", S_AXIS_tready, 0);
    chk("bp_hold_data", M_AXIS_tdata, vecs[0].dout);
    M_AXIS_tready = 1'b1;
    step();
    chk("bp_b_data", M_AXIS_tdata, vecs[3].dout);
    chk("bp_b_tready", S_AXIS_tready, 1);
    step();
    S_AXIS_tvalid = 1'b0;
    chk("bp_c_data", M_AXIS_tdata, vecs[5].dout);
    chk("bp_c_tvalid", M_AXIS_tvalid, 1);
    step();
    chk("bp_c_once", M_AXIS_tvalid, 0);

    // random handshakes against a queue model
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 1000 && cyc < 20000) begin
      if (!S_AXIS_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        S_AXIS_tdata  = {rnd_lane(), rnd_lane()};
        S_AXIS_tvalid = 1'b1;
      end
      M_AXIS_tready = ($urandom_range(0, 2) != 0);
      #1;
      acc  = S_AXIS_tvalid && S_AXIS_tready;
      cons = M_AXIS_tvalid && M_AXIS_tready;
      if (cons) begin
        if (q.size() == 0) begin
          chk("rnd_extra_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_tdata", M_AXIS_tdata, e[63:0]);
          chk("rnd_aux", M_AXIS_aux_tdata, e[79:64]);
        end
        got++;
      end
      if (acc) begin
        cl = 0;
        q.push_back(model(S_AXIS_tdata, cl));
        if (SAT_ON) exp_sat += cl;
        sent++;
      end
      step();
      if (acc) S_AXIS_tvalid = 1'b0;
      cyc++;
    end
    chk("rnd_beats_out", got, 1000);
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_sat", sat_count, exp_sat);
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    step();
    step();

    // reset while FULL drops both buffered beats
    M_AXIS_tready = 1'b0;
    S_AXIS_tdata  = 32'h80004000;
    S_AXIS_tvalid = 1'b1;
    step();
    step();
    S_AXIS_tvalid = 1'b0;
    chk("full_tready", S_AXIS_tready, 0);
    chk("full_sat", sat_count, SAT_ON ? exp_sat + 4 : 0);
    a_rst = 1'b1;
    step();
    chk("midrst_tvalid", M_AXIS_tvalid, 0);
    chk("midrst_tready", S_AXIS_tready, 0);
    chk("midrst_tdata", M_AXIS_tdata, 0);
    chk("midrst_aux", M_AXIS_aux_tdata, 0);
    chk("midrst_sat", sat_count, 0);
    a_rst = 1'b0;
    M_AXIS_tready = 1'b1;
    step();
    chk("after_rst_tready", S_AXIS_tready, 1);
    chk("after_rst_tvalid", M_AXIS_tvalid, 0);
    step();
    chk("after_rst_no_beat", M_AXIS_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
